nibble_sub32_seq: RTL
=====================

Name: nibble_sub32_seq

Overview:
- Multi-cycle 32-bit subtractor: s = a - b, 4 bits per clock, LSB slice first, borrow rippled through a register between slices.
- Reverse operation of the team's 32-bit ripple-carry adder; reuses its 4-bit-slice structure in time rather than space.
- Used where area matters more than latency. Start/busy/done handshake to the controlling FSM.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per clock.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend, captured on the accepted start edge.
- b  input  WIDTH  subtrahend, captured on the accepted start edge.
- s  output  WIDTH  difference a-b; registered, held until the next completion.
- bo  output  1  borrow out: 1 when unsigned a < b.
- ovf  output  1  signed (two's-complement) overflow of a-b.
- zero  output  1  s == 0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: s/bo/ovf/zero just updated.

Behaviour:
- Clock and reset are decided: one clock; reset is synchronous and active-high.
- Reset: on an edge with reset=1, s=0, bo=0, ovf=0, zero=0, busy=0, done=0, and the slice counter clears. Reset overrides start. Reset mid-operation aborts it; no done pulse follows.
- States: IDLE (busy=0) and RUN (busy=1). N = WIDTH/SLICE = 8 slices.
- IDLE -> RUN on an edge with start=1:
  - Latch a and b into internal shift registers; latch a[WIDTH-1] and b[WIDTH-1] for the overflow check.
  - Set cnt=0 and internal borrow=0.
  - Set busy=1 and done=0.
- RUN, each edge:
  - Compute the slice {bout, d[3:0]} = a_sh[3:0] - b_sh[3:0] - borrow, using 5-bit arithmetic; bout is the inverted carry.
  - Shift d into the result accumulator from the MSB end; shift a_sh and b_sh right by SLICE.
  - Set borrow=bout and cnt=cnt+1.
- On the edge that processes slice N-1:
  - Load s from the accumulator, including this slice's d.
  - bo = final bout.
  - ovf = (a_msb != b_msb) && (s[WIDTH-1] != a_msb).
  - zero = (s == 0).
  - Set busy=0 and done=1, then return to IDLE.
- Latency: start accepted at edge E0. Slices are processed at edges E1..E8. done=1, busy=0 and results are valid in the cycle after E8. busy=1 in the cycles after E0..E7.
- done is high for exactly one cycle, then clears at the next edge.
- start while busy=1 is ignored: no effect and no queuing.
- start in the done cycle is legal (busy=0). It is accepted back-to-back, and done clears on that same edge.
- s/bo/ovf/zero change only on the completion edge or reset. They keep the previous result throughout a new operation.
- a and b may change freely after the accepted edge.
- cnt wraps internally; there is no behaviour beyond N slices.

Test Plan:
- a=5, b=3, start pulse -> busy high 8 cycles; then done=1 for one cycle with s=0x00000002, bo=0, ovf=0, zero=0.
- a=0, b=1 -> s=0xFFFFFFFF, bo=1, ovf=0, zero=0. Then a=0x1234ABCD, b=0x1234ABCD -> s=0, zero=1, bo=0.
- a=0x80000000, b=1 -> s=0x7FFFFFFF, ovf=1, bo=0. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> s=0x80000000, ovf=1, bo=1.
- Start a=10, b=4; re-assert start with a=99, b=1 at cycle 3 -> ignored; done exactly 8 cycles after the first start with s=6; no second done.
- Start a=100, b=1; assert reset at cycle 4 -> next cycle all outputs 0, busy=0, no done. Then a fresh a=7, b=7 -> s=0, zero=1 after 8 cycles.
- Assert start with a=20, b=5 during the done cycle of a prior a=9, b=2 -> first result s=7. Second done 8 cycles later with s=15. s holds 7 in between.

Source files
------------

// File: rtl/nibble_sub32_seq.sv
// nibble_sub32_seq: multi-cycle subtractor s = a - b, SLICE bits per clock, LSB slice first
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   start                request, accepted only while busy=0
//   a, b                 minuend / subtrahend, captured on the accepted start edge
//   s, bo, ovf, zero     registered result, unsigned borrow, signed overflow, zero flag
//   busy, done           operation in progress / one-cycle completion pulse
module nibble_sub32_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             bo,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, acc_q, acc_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             bo_q, bo_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;
    logic [SLICE:0]   diff;
    logic [WIDTH-1:0] res;
    // The extra top bit of the widened difference is set exactly when the slice borrows.
    assign diff = {1'b0, a_sh_q[SLICE-1:0]} - {1'b0, b_sh_q[SLICE-1:0]} - {{SLICE{1'b0}}, brw_q};
    // Accumulator fills from the MSB end, so after N slices the LSB slice sits at the bottom.
    assign res  = {diff[SLICE-1:0], acc_q[WIDTH-1:SLICE]};
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        s_d     = s_q;
        bo_d    = bo_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        if (state_q == IDLE && start) begin
            state_d = RUN;
            a_sh_d  = a;
            b_sh_d  = b;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
            cnt_d   = '0;
            brw_d   = 1'b0;
        end else if (state_q == RUN) begin
            a_sh_d = a_sh_q >> SLICE;
            b_sh_d = b_sh_q >> SLICE;
            acc_d  = res;
            brw_d  = diff[SLICE];
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
                state_d = IDLE;
                s_d     = res;
                bo_d    = diff[SLICE];
                ovf_d   = (a_msb_q != b_msb_q) && (res[WIDTH-1] != a_msb_q);
                zero_d  = (res == '0);
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            s_q     <= '0;
            bo_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            s_q     <= s_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end
    assign s    = s_q;
    assign bo   = bo_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
endmodule
